axis_frame_to_axi_wr: RTL and testbench
=======================================

Name: axis_frame_to_axi_wr

Overview:
- Accepts AXI-Stream frames and writes them into a circular buffer in memory through an AXI4 master write channel (AW/W/B), using fixed-length INCR bursts.
- Pads a short final burst with zero-strobe beats.
- Truncates frames longer than a limit and discards the remainder up to tlast.
- Sits between the packet-framing stream path and the PS DDR port; reports per-frame status to the control/status register block.

Parameters:
- DATA_WIDTH, 64, AXIS and AXI data width in bits; multiple of 8.
- ADDR_WIDTH, 32, AXI address width.
- BURST_LEN, 16, beats per AXI burst; power of 2, 1..256.
- MAX_FRAME_BEATS, 256, maximum beats written per frame; multiple of BURST_LEN.
- RING_BURSTS, 64, ring size in bursts; power of 2.
- MAX_OUTSTANDING, 4, maximum bursts with W complete and B pending; 1..15.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  async active-low reset
- cfg_enable  in  1  enables acceptance of new frames
- cfg_base_addr  in  ADDR_WIDTH  ring base; aligned to BURST_LEN*DATA_WIDTH/8 bytes; sampled only in IDLE
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tkeep  in  DATA_WIDTH/8  byte qualifiers
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  end of frame
- m_axi_awaddr  out  ADDR_WIDTH  burst address
- m_axi_awlen  out  8  constant BURST_LEN-1
- m_axi_awsize  out  3  constant log2(DATA_WIDTH/8)
- m_axi_awburst  out  2  constant 2'b01 INCR
- m_axi_awvalid  out  1  address valid
- m_axi_awready  in  1  address ready
- m_axi_wdata  out  DATA_WIDTH  write data
- m_axi_wstrb  out  DATA_WIDTH/8  write strobes
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid  out  1  write valid
- m_axi_wready  in  1  write ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  constant 1
- frame_done  out  1  one-cycle pulse at the final W handshake of a frame
- frame_beats  out  clog2(MAX_FRAME_BEATS)+1  beats written for the frame; valid with frame_done
- frame_trunc  out  1  frame was truncated; valid with frame_done
- bresp_err  out  1  sticky: any bresp != OKAY; cleared only by reset
- outstanding  out  4  bursts awaiting B

Behaviour:
- Reset values:
  - all valids, s_axis_tready, frame_done, frame_trunc, bresp_err = 0
  - outstanding = 0; frame_beats = 0; ring burst index = 0
  - awaddr = 0; wdata, wstrb, wlast = 0
- States: IDLE, ADDR, DATA, PAD, DROP.
- IDLE: s_axis_tready=0. Move to ADDR when all hold: cfg_enable=1, s_axis_tvalid=1, outstanding < MAX_OUTSTANDING.
- ADDR:
  - awvalid=1; awaddr = cfg_base_addr + idx*BURST_LEN*DATA_WIDTH/8.
  - awaddr is held stable until awready. On handshake: go to DATA, reset beat counter, idx = (idx+1) mod RING_BURSTS (wrap to 0).
  - Re-entering ADDR mid-frame also requires outstanding < MAX_OUTSTANDING; otherwise hold with awvalid=0.
- DATA:
  - Combinational pass-through: s_axis_tready = m_axi_wready; wvalid = s_axis_tvalid; wdata = tdata.
  - wlast=1 when beat counter = BURST_LEN-1.
  - Per accepted beat, in priority order:
    - tlast and burst end -> frame end, go to IDLE.
    - tlast not at burst end -> PAD.
    - frame beat count reaches MAX_FRAME_BEATS without tlast -> set trunc; go to DROP (that beat completes its burst, since the limit is a BURST_LEN multiple).
    - burst end -> ADDR.
- PAD: wvalid=1, wstrb=0, wdata=0, s_axis_tready=0 until the wlast handshake, then IDLE. Pad beats are not counted in frame_beats.
- DROP: s_axis_tready=1, no W traffic; beats are discarded until the tlast handshake, then IDLE.
- frame_done:
  - Pulses on the final data or pad wlast handshake; for truncated frames, on the last handshake at the limit.
  - frame_beats counts only real data beats; maximum value is MAX_FRAME_BEATS.
- outstanding:
  - +1 on each wlast handshake, -1 on each bvalid.
  - When both occur in the same cycle, it is unchanged. Never underflows.
- No AXI combinational path except the DATA-state pass-through of ready/valid.
- cfg_enable deassertion mid-frame has no effect until IDLE.
- Reset mid-burst abandons the transaction; the interconnect is reset with the block.

Optional Feature:
- Macro A2A_KEEP_TO_STRB_EN.
- Defined: data-beat wstrb = s_axis_tkeep.
- Undefined: data-beat wstrb is all ones and tkeep is ignored.
- Pad beats are always wstrb=0 in both builds.

Test Plan:
- BURST_LEN=4; 8-beat frame, data 1..8, always-ready slave -> two AW at base and base+32 (64-bit data); wlast on beats 4 and 8; frame_done with frame_beats=8, frame_trunc=0.
- 6-beat frame -> two bursts; beats 7 and 8 have wstrb=0x00 and wdata=0; frame_beats=6; s_axis_tready=0 during pad.
- MAX_FRAME_BEATS=8; 11-beat frame -> 8 beats written; 3 beats accepted and dropped; frame_trunc=1; the next frame's AW index continues from the wrap.
- RING_BURSTS=2; three 4-beat frames -> awaddr sequence base, base+32, base.
- MAX_OUTSTANDING=2 with bvalid withheld -> after two bursts, awvalid stays 0 and outstanding=2. Release one B with bresp=2'b10 -> transfer resumes and bresp_err=1 (sticky).
- Random wready/tvalid stalls on a 16-beat frame -> data order is preserved and awaddr is stable while awvalid=1 and awready=0.

Source files
------------

// File: rtl/axis_frame_to_axi_wr.sv
// AXI-Stream frame to AXI4 fixed-length INCR burst writer into a memory ring buffer.
// Build macro A2A_KEEP_TO_STRB_EN: data-beat wstrb follows s_axis_tkeep (otherwise all ones).
module axis_frame_to_axi_wr #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned MAX_FRAME_BEATS = 256,
  parameter int unsigned RING_BURSTS     = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic                              cfg_enable,
  input  logic [ADDR_WIDTH-1:0]             cfg_base_addr,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]           s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DATA_WIDTH-1:0]             m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic                              frame_done,
  output logic [$clog2(MAX_FRAME_BEATS):0]  frame_beats,
  output logic                              frame_trunc,
  output logic                              bresp_err,
  output logic [3:0]                        outstanding
);

  localparam int unsigned STRB_W      = DATA_WIDTH / 8;
  localparam int unsigned BCNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned FB_W        = $clog2(MAX_FRAME_BEATS) + 1;
  localparam int unsigned IDX_W       = (RING_BURSTS > 1) ? $clog2(RING_BURSTS) : 1;
  localparam int unsigned BURST_BYTES = BURST_LEN * STRB_W;

  localparam logic [BCNT_W-1:0] LAST_BEAT   = BCNT_W'(BURST_LEN - 1);
  localparam logic [FB_W-1:0]   FRAME_LIMIT = FB_W'(MAX_FRAME_BEATS);
  localparam logic [3:0]        OUT_LIMIT   = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_PAD, S_DROP} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [BCNT_W-1:0]      beat_cnt;
  logic [FB_W-1:0]        frame_cnt;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic                   pad_valid;
  logic                   drop_ready;

  logic                   in_data;
  logic                   w_hs;
  logic                   s_hs;
  logic                   burst_end;
  logic                   can_issue;
  logic                   b_inc;
  logic                   b_dec;
  logic [BCNT_W-1:0]      beat_nxt;
  logic [FB_W-1:0]        frame_nxt;
  logic [IDX_W-1:0]       idx_nxt;
  logic [ADDR_WIDTH-1:0]  ring_off;
  logic [STRB_W-1:0]      data_strb;

  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(STRB_W));
  assign m_axi_awburst = 2'b01;
  assign m_axi_bready  = 1'b1;

`ifdef A2A_KEEP_TO_STRB_EN
  assign data_strb = s_axis_tkeep;
`else
  logic unused_keep;
  assign unused_keep = ^s_axis_tkeep;
  assign data_strb   = '1;
`endif

  // Only the DATA state passes stream/W handshakes through; elsewhere outputs come from flops.
  assign in_data       = (state == S_DATA);
  assign s_axis_tready = in_data ? m_axi_wready  : drop_ready;
  assign m_axi_wvalid  = in_data ? s_axis_tvalid : pad_valid;
  assign m_axi_wdata   = in_data ? s_axis_tdata  : '0;
  assign m_axi_wstrb   = in_data ? data_strb     : '0;

  assign w_hs      = m_axi_wvalid && m_axi_wready;
  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign burst_end = (beat_cnt == LAST_BEAT);
  assign can_issue = (outstanding < OUT_LIMIT);
  assign b_inc     = w_hs && m_axi_wlast;
  assign b_dec     = m_axi_bvalid && (outstanding != 4'd0);
  assign beat_nxt  = beat_cnt + 1'b1;
  assign frame_nxt = frame_cnt + 1'b1;
  assign idx_nxt   = (RING_BURSTS == 1) ? '0 : idx + 1'b1;
  assign ring_off  = ADDR_WIDTH'(idx) * ADDR_WIDTH'(BURST_BYTES);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state         <= S_IDLE;
      idx           <= '0;
      beat_cnt      <= '0;
      frame_cnt     <= '0;
      base_q        <= '0;
      pad_valid     <= 1'b0;
      drop_ready    <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wlast   <= 1'b0;
      frame_done    <= 1'b0;
      frame_beats   <= '0;
      frame_trunc   <= 1'b0;
      bresp_err     <= 1'b0;
      outstanding   <= '0;
    end else begin
      frame_done  <= 1'b0;
      outstanding <= outstanding + 4'(b_inc) - 4'(b_dec);
      if (m_axi_bvalid && (m_axi_bresp != 2'b00)) bresp_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cfg_enable && s_axis_tvalid && can_issue) begin
            state         <= S_ADDR;
            base_q        <= cfg_base_addr;
            m_axi_awaddr  <= cfg_base_addr + ring_off;
            m_axi_awvalid <= 1'b1;
            frame_cnt     <= '0;
          end
        end
        S_ADDR: begin
          // awvalid, once raised, is held with a stable address until accepted
          if (m_axi_awvalid) begin
            if (m_axi_awready) begin
              m_axi_awvalid <= 1'b0;
              state         <= S_DATA;
              beat_cnt      <= '0;
              idx           <= idx_nxt;
              m_axi_wlast   <= (BURST_LEN == 1);
            end
          end else if (can_issue) begin
            m_axi_awvalid <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            beat_cnt    <= beat_nxt;
            frame_cnt   <= frame_nxt;
            m_axi_wlast <= (beat_nxt == LAST_BEAT) && !burst_end;
            if (s_axis_tlast && burst_end) begin
              state       <= S_IDLE;
              frame_done  <= 1'b1;
              frame_beats <= frame_nxt;
              frame_trunc <= 1'b0;
            end else if (s_axis_tlast) begin
              state     <= S_PAD;
              pad_valid <= 1'b1;
            end else if (frame_nxt == FRAME_LIMIT) begin
              state       <= S_DROP;
              drop_ready  <= 1'b1;
              frame_done  <= 1'b1;
              frame_beats <= frame_nxt;
              frame_trunc <= 1'b1;
            end else if (burst_end) begin
              state        <= S_ADDR;
              m_axi_awaddr <= base_q + ring_off;
            end
          end
        end
        S_PAD: begin
          if (w_hs) begin
            beat_cnt    <= beat_nxt;
            m_axi_wlast <= (beat_nxt == LAST_BEAT) && !burst_end;
            if (burst_end) begin
              state       <= S_IDLE;
              pad_valid   <= 1'b0;
              frame_done  <= 1'b1;
              frame_beats <= frame_cnt;
              frame_trunc <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (s_hs && s_axis_tlast) begin
            state      <= S_IDLE;
            drop_ready <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_to_axi_wr.sv
// Scoreboard bench for axis_frame_to_axi_wr: expected AW/W/frame results queued at stimulus time.
module tb_axis_frame_to_axi_wr;

  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int BL  = 4;
  localparam int MFB = 8;
  localparam int RB  = 2;
  localparam int MO  = 2;
  localparam logic [31:0] BASE = 32'h1000_0400;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        pad;
  } wexp_t;

  typedef struct packed {
    logic [3:0] beats;
    logic       trunc;
  } dexp_t;

  logic          clk;
  logic          rst_n;
  logic          cfg_enable;
  logic [AW-1:0] cfg_base_addr;
  logic [DW-1:0] s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic          frame_done;
  logic [3:0]    frame_beats;
  logic          frame_trunc;
  logic          bresp_err;
  logic [3:0]    outstanding;

  wexp_t       wq[$];
  logic [31:0] awq[$];
  dexp_t       dq[$];

  int checks    = 0;
  int errors    = 0;
  int model_idx = 0;
  int b_issued  = 0;
  int b_sent    = 0;
  int b_limit   = 1 << 30;
  logic [1:0] bresp_val = 2'b00;
  bit rnd_ready = 0;

  axis_frame_to_axi_wr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL),
    .MAX_FRAME_BEATS(MFB), .RING_BURSTS(RB), .MAX_OUTSTANDING(MO)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .frame_done(frame_done), .frame_beats(frame_beats), .frame_trunc(frame_trunc),
    .bresp_err(bresp_err), .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] strb_of(input logic [7:0] keep);
`ifdef A2A_KEEP_TO_STRB_EN
    return keep;
`else
    return (keep == 8'h00) ? 8'hFF : 8'hFF;
`endif
  endfunction

  // Queue the expected bus activity for one frame, then drive its beats.
  task automatic send_frame(input int n, input logic [63:0] d0, input logic [7:0] last_keep,
                            input bit stall);
    int written;
    int bursts;
    int to;
    dexp_t d;
    written = (n > MFB) ? MFB : n;
    bursts  = (written + BL - 1) / BL;
    for (int b = 0; b < bursts; b++) begin
      awq.push_back(BASE + 32'(model_idx * BL * 8));
      model_idx = (model_idx + 1) % RB;
    end
    for (int i = 0; i < bursts * BL; i++) begin
      wexp_t e;
      e.last = ((i % BL) == BL - 1);
      if (i < written) begin
        e.data = d0 + 64'(i);
        e.strb = strb_of((i == n - 1) ? last_keep : 8'hFF);
        e.pad  = 1'b0;
      end else begin
        e.data = '0;
        e.strb = '0;
        e.pad  = 1'b1;
      end
      wq.push_back(e);
    end
    d.beats = 4'(written);
    d.trunc = (n > MFB);
    dq.push_back(d);

    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d0 + 64'(i);
      s_axis_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
      s_axis_tlast  = (i == n - 1);
      to = 0;
      do begin @(negedge clk); to++; end while (!s_axis_tready && to < 2000);
      if (!s_axis_tready) begin
        check("tready_timeout", 64'(s_axis_tready), 64'(1));
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int to;
    to = 0;
    while ((wq.size() != 0 || awq.size() != 0 || dq.size() != 0 || outstanding != 4'd0 ||
            b_sent != b_issued) && to < 3000) begin
      @(negedge clk);
      to++;
    end
    @(negedge clk);
    check({tag, "_wq"}, 64'(wq.size()), 64'(0));
    check({tag, "_awq"}, 64'(awq.size()), 64'(0));
    check({tag, "_dq"}, 64'(dq.size()), 64'(0));
    check({tag, "_outstanding"}, 64'(outstanding), 64'(0));
  endtask

  // AXI slave: ready generation and B responses gated by b_limit.
  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    @(posedge rst_n);
    forever begin
      @(posedge clk); #1;
      wready  = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      awready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      bvalid  = 1'b0;
      if (b_sent < b_issued && b_sent < b_limit) begin
        bvalid = 1'b1;
        bresp  = bresp_val;
        b_sent++;
      end
    end
  end

  // Monitor: compares AW, W and frame status against the queues.
  initial begin
    bit          aw_pend;
    logic [31:0] aw_hold;
    wexp_t       e;
    dexp_t       d;
    aw_pend = 1'b0;
    aw_hold = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (aw_pend) check("aw_stable", 64'({awvalid, awaddr}), 64'({1'b1, aw_hold}));
        aw_pend = awvalid && !awready;
        aw_hold = awaddr;
        if (awvalid && awready) begin
          if (awq.size() == 0) check("aw_unexpected", 64'(awq.size()), 64'(1));
          else check("awaddr", 64'(awaddr), 64'(awq.pop_front()));
        end
        if (wvalid && wready) begin
          if (wq.size() == 0) begin
            check("w_unexpected", 64'(wq.size()), 64'(1));
          end else begin
            e = wq.pop_front();
            check("wdata", wdata, e.data);
            check("wstrb", 64'(wstrb), 64'(e.strb));
            check("wlast", 64'(wlast), 64'(e.last));
            if (e.pad) check("tready_in_pad", 64'(s_axis_tready), 64'(0));
          end
          if (wlast) b_issued++;
        end
        if (frame_done) begin
          if (dq.size() == 0) begin
            check("done_unexpected", 64'(dq.size()), 64'(1));
          end else begin
            d = dq.pop_front();
            check("frame_beats", 64'(frame_beats), 64'(d.beats));
            check("frame_trunc", 64'(frame_trunc), 64'(d.trunc));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    cfg_enable    = 1'b0;
    cfg_base_addr = BASE;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awvalid", 64'(awvalid), 64'(0));
    check("rst_awaddr", 64'(awaddr), 64'(0));
    check("rst_wvalid", 64'(wvalid), 64'(0));
    check("rst_wdata", wdata, 64'(0));
    check("rst_wstrb_wlast", 64'({wstrb, wlast}), 64'(0));
    check("rst_tready", 64'(s_axis_tready), 64'(0));
    check("rst_status", 64'({frame_done, frame_trunc, bresp_err, frame_beats, outstanding}), 64'(0));
    check("const_aw", 64'({awlen, awsize, awburst, bready}), 64'({8'd3, 3'd3, 2'b01, 1'b1}));
    @(posedge clk); #1;
    rst_n      = 1'b1;
    cfg_enable = 1'b1;

    send_frame(8, 64'd1, 8'hFF, 1'b0);
    send_frame(6, 64'h110, 8'h0F, 1'b0);
    send_frame(11, 64'h220, 8'hFF, 1'b0);
    send_frame(4, 64'h330, 8'hFF, 1'b0);
    send_frame(4, 64'h340, 8'hFF, 1'b0);
    send_frame(4, 64'h350, 8'hFF, 1'b0);
    wait_drain("basic");

    // Withhold B responses: the outstanding limit must block the next frame.
    b_limit = b_sent;
    send_frame(8, 64'h440, 8'hFF, 1'b0);
    fork
      send_frame(4, 64'h460, 8'hFF, 1'b0);
    join_none
    repeat (20) @(negedge clk);
    check("hold_awvalid", 64'(awvalid), 64'(0));
    check("hold_outstanding", 64'(outstanding), 64'(2));
    check("hold_tready", 64'(s_axis_tready), 64'(0));
    check("hold_bresp_err", 64'(bresp_err), 64'(0));
    @(posedge clk); #1;
    bresp_val = 2'b10;
    b_limit   = b_sent + 1;
    wait fork;
    @(posedge clk); #1;
    bresp_val = 2'b00;
    b_limit   = 1 << 30;
    @(negedge clk);
    check("bresp_err_set", 64'(bresp_err), 64'(1));
    wait_drain("hold");

    @(posedge clk); #1;
    rnd_ready = 1'b1;
    send_frame(16, 64'h5000, 8'hFF, 1'b1);
    send_frame(5, 64'h6000, 8'h03, 1'b1);
    send_frame(7, 64'h7000, 8'h01, 1'b1);
    wait_drain("random");
    rnd_ready = 1'b0;
    check("bresp_err_sticky", 64'(bresp_err), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
